// File: rtl/high_score_tracker.sv
// high_score_tracker: keeps the best BCD score across games.
// On the game-over pulse the live score is snapshotted and then compared
// against the stored best one digit per clock, most significant digit first.
// A strictly greater snapshot replaces the best and raises the new-record
// flag, which drives a blink phase clocked by the 60 Hz game tick.
module high_score_tracker #(
  parameter int DIGITS       = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_game_start_pulse,
  input  logic                  i_game_over_pulse,
  input  logic                  i_game_tick_60hz,
  input  logic [4*DIGITS-1:0]   i_score,
  output logic [4*DIGITS-1:0]   o_high_score,
  output logic                  o_new_record,
  output logic                  o_record_blink,
  output logic                  o_busy
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IW-1:0] IDX_MSD  = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t          state;
  logic [W-1:0]    snap;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   blink_cnt;
  logic [3:0]      snap_digit;
  logic [3:0]      high_digit;

  // Select the digit pair currently under comparison.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    snap_digit = 4'd0;
    high_digit = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx == IW'(d)) begin
        snap_digit = snap[4*d +: 4];
        high_digit = o_high_score[4*d +: 4];
      end
    end
  end

  // Compare FSM, best-score register, record flag and blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state          <= IDLE;
      snap           <= '0;
      idx            <= IDX_MSD;
      blink_cnt      <= '0;
      o_high_score   <= '0;
      o_new_record   <= 1'b0;
      o_record_blink <= 1'b0;
      o_busy         <= 1'b0;
    end else if (i_game_start_pulse) begin
      // A new game clears the record flags and abandons any comparison;
      // it also suppresses a game-over arriving in the same cycle.
      state          <= IDLE;
      o_busy         <= 1'b0;
      o_new_record   <= 1'b0;
      o_record_blink <= 1'b0;
      blink_cnt      <= '0;
    end else begin
      // Blink phase runs only while a record is being shown.
      if (o_new_record && i_game_tick_60hz) begin
        if (blink_cnt == CNT_LAST) begin
          blink_cnt      <= '0;
          o_record_blink <= ~o_record_blink;
        end else begin
          blink_cnt <= blink_cnt + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (i_game_over_pulse) begin
            snap   <= i_score;
            idx    <= IDX_MSD;
            state  <= COMPARE;
            o_busy <= 1'b1;
          end
        end

        COMPARE: begin
          if (snap_digit > high_digit) begin
            // New record; these assignments override the blink update above,
            // so a tick landing on this edge is not counted.
            o_high_score   <= snap;
            o_new_record   <= 1'b1;
            o_record_blink <= 1'b1;
            blink_cnt      <= '0;
            state          <= IDLE;
            o_busy         <= 1'b0;
          end else if (snap_digit < high_digit) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (idx == '0) begin
            // All digits equal: a tie never counts as a record.
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            idx <= idx - IW'(1);
          end
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
